// File: rtl/regfile_sb.sv
// Integer register file with two write-back ports, optional write-to-read bypass
// and a per-register pending scoreboard with an incremental pending counter.
module regfile_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_num,
    input  logic [AW-1:0]   rs2_num,
    output logic [XLEN-1:0] rs1_value,
    output logic [XLEN-1:0] rs2_value,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            we0,
    input  logic [AW-1:0]   wd0_num,
    input  logic [XLEN-1:0] wd0_value,
    input  logic            we1,
    input  logic [AW-1:0]   wd1_num,
    input  logic [XLEN-1:0] wd1_value,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_num,
    output logic [AW:0]     pending_cnt
);

    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] pending_q, pending_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic w0_hit, w1_hit, iss_hit;
    logic inc, dec0, dec1;

    // Index 0 is never a real destination, so it is filtered here once.
    assign w0_hit  = we0 && (wd0_num != '0);
    assign w1_hit  = we1 && (wd1_num != '0);
    assign iss_hit = issue_en && (issue_num != '0);

    // Next register contents: port 0 applied last so it wins a same-index conflict.
    always_comb begin
        regs_d = regs_q;
        if (w1_hit) regs_d[wd1_num] = wd1_value;
        if (w0_hit) regs_d[wd0_num] = wd0_value;
        regs_d[0] = '0;
    end

    // Scoreboard: writes retire, a same-cycle issue re-arms the bit.
    always_comb begin
        pending_d = pending_q;
        if (w0_hit)  pending_d[wd0_num]   = 1'b0;
        if (w1_hit)  pending_d[wd1_num]   = 1'b0;
        if (iss_hit) pending_d[issue_num] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // Counter deltas; a bit cleared and re-set in one cycle is a net no-op,
    // and both ports retiring the same register count once.
    always_comb begin
        inc  = iss_hit && !pending_q[issue_num];
        dec0 = w0_hit && pending_q[wd0_num]
               && !(iss_hit && (issue_num == wd0_num));
        dec1 = w1_hit && pending_q[wd1_num]
               && !(iss_hit && (issue_num == wd1_num))
               && !(w0_hit && (wd0_num == wd1_num));
        cnt_d = cnt_q + CW'(inc) - CW'(dec0) - CW'(dec1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= regs_d[i];
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_cnt = cnt_q;

    // Read port 1
    always_comb begin
        rs1_value = regs_q[rs1_num];
        rs1_busy  = pending_q[rs1_num];
        if (BYPASS != 0) begin
            if (w0_hit && (wd0_num == rs1_num)) begin
                rs1_value = wd0_value;
                rs1_busy  = 1'b0;
            end else if (w1_hit && (wd1_num == rs1_num)) begin
                rs1_value = wd1_value;
                rs1_busy  = 1'b0;
            end
        end
        if (rs1_num == '0) begin
            rs1_value = '0;
            rs1_busy  = 1'b0;
        end
    end

    // Read port 2
    always_comb begin
        rs2_value = regs_q[rs2_num];
        rs2_busy  = pending_q[rs2_num];
        if (BYPASS != 0) begin
            if (w0_hit && (wd0_num == rs2_num)) begin
                rs2_value = wd0_value;
                rs2_busy  = 1'b0;
            end else if (w1_hit && (wd1_num == rs2_num)) begin
                rs2_value = wd1_value;
                rs2_busy  = 1'b0;
            end
        end
        if (rs2_num == '0) begin
            rs2_value = '0;
            rs2_busy  = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a bypassing and a non-bypassing instance share stimulus
// and are checked every cycle against an array/popcount reference model.
module tb_regfile_sb;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   rs1_num, rs2_num;
    logic            we0, we1, issue_en;
    logic [AW-1:0]   wd0_num, wd1_num, issue_num;
    logic [XLEN-1:0] wd0_value, wd1_value;

    logic [XLEN-1:0] b_rs1_value, b_rs2_value, n_rs1_value, n_rs2_value;
    logic            b_rs1_busy, b_rs2_busy, n_rs1_busy, n_rs2_busy;
    logic [AW:0]     b_cnt, n_cnt;

    int  n_cmp = 0;
    int  n_err = 0;
    bit  check_en = 1'b0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rs1_num(rs1_num), .rs2_num(rs2_num),
        .rs1_value(b_rs1_value), .rs2_value(b_rs2_value),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .we0(we0), .wd0_num(wd0_num), .wd0_value(wd0_value),
        .we1(we1), .wd1_num(wd1_num), .wd1_value(wd1_value),
        .issue_en(issue_en), .issue_num(issue_num),
        .pending_cnt(b_cnt)
    );

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(0)) dut_n (
        .clk(clk), .rst_n(rst_n),
        .rs1_num(rs1_num), .rs2_num(rs2_num),
        .rs1_value(n_rs1_value), .rs2_value(n_rs2_value),
        .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
        .we0(we0), .wd0_num(wd0_num), .wd0_value(wd0_value),
        .we1(we1), .wd1_num(wd1_num), .wd1_value(wd1_value),
        .issue_en(issue_en), .issue_num(issue_num),
        .pending_cnt(n_cnt)
    );

    // Reference model: architectural values and the set of pending registers.
    logic [XLEN-1:0] m_regs [NREG];
    logic [NREG-1:0] m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) m_regs[i] = '0;
            m_pend = '0;
        end else begin
            if (we1 && wd1_num != 0) m_regs[wd1_num] = wd1_value;
            if (we0 && wd0_num != 0) m_regs[wd0_num] = wd0_value;
            if (we0 && wd0_num != 0) m_pend[wd0_num] = 1'b0;
            if (we1 && wd1_num != 0) m_pend[wd1_num] = 1'b0;
            if (issue_en && issue_num != 0) m_pend[issue_num] = 1'b1;
        end
    end

    function automatic logic [XLEN-1:0] exp_val(input logic [AW-1:0] n, input bit byp);
        if (n == 0) return '0;
        if (byp && we0 && wd0_num == n) return wd0_value;
        if (byp && we1 && wd1_num == n) return wd1_value;
        return m_regs[n];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] n, input bit byp);
        if (n == 0) return 1'b0;
        if (byp && ((we0 && wd0_num == n) || (we1 && wd1_num == n))) return 1'b0;
        return m_pend[n];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("b_rs1_value", 64'(b_rs1_value), 64'(exp_val(rs1_num, 1'b1)));
            chk("b_rs2_value", 64'(b_rs2_value), 64'(exp_val(rs2_num, 1'b1)));
            chk("b_rs1_busy",  64'(b_rs1_busy),  64'(exp_busy(rs1_num, 1'b1)));
            chk("b_rs2_busy",  64'(b_rs2_busy),  64'(exp_busy(rs2_num, 1'b1)));
            chk("n_rs1_value", 64'(n_rs1_value), 64'(exp_val(rs1_num, 1'b0)));
            chk("n_rs2_value", 64'(n_rs2_value), 64'(exp_val(rs2_num, 1'b0)));
            chk("n_rs1_busy",  64'(n_rs1_busy),  64'(exp_busy(rs1_num, 1'b0)));
            chk("n_rs2_busy",  64'(n_rs2_busy),  64'(exp_busy(rs2_num, 1'b0)));
            chk("b_cnt", 64'(b_cnt), 64'($countones(m_pend)));
            chk("n_cnt", 64'(n_cnt), 64'($countones(m_pend)));
        end
    end

    task automatic idle();
        we0 = 1'b0; wd0_num = '0; wd0_value = '0;
        we1 = 1'b0; wd1_num = '0; wd1_value = '0;
        issue_en = 1'b0; issue_num = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rnd_idx();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        rs1_num = 5'd3; rs2_num = 5'd4;
        #3;
        chk("rst_cnt", 64'(b_cnt), 64'd0);
        chk("rst_rs1", 64'(b_rs1_value), 64'd0);
        #9 rst_n = 1'b1;
        check_en = 1'b1;
        tick();

        // x0 writes and issues are discarded
        we0 = 1'b1; wd0_num = 5'd0; wd0_value = 32'hDEADBEEF;
        issue_en = 1'b1; issue_num = 5'd0; rs1_num = 5'd0;
        @(negedge clk);
        chk("x0_val", 64'(b_rs1_value), 64'd0);
        chk("x0_busy", 64'(b_rs1_busy), 64'd0);
        tick(); idle();
        @(negedge clk);
        chk("x0_cnt", 64'(b_cnt), 64'd0);
        chk("x0_val2", 64'(n_rs1_value), 64'd0);
        tick();

        // Same-index dual write: port 0 wins
        we0 = 1'b1; wd0_num = 5'd5; wd0_value = 32'h1111;
        we1 = 1'b1; wd1_num = 5'd5; wd1_value = 32'h2222;
        tick(); idle(); rs1_num = 5'd5;
        @(negedge clk);
        chk("dual_b", 64'(b_rs1_value), 64'h1111);
        chk("dual_n", 64'(n_rs1_value), 64'h1111);
        tick();

        // Bypass vs. no-bypass on a pending register
        issue_en = 1'b1; issue_num = 5'd7;
        tick(); idle();
        we1 = 1'b1; wd1_num = 5'd7; wd1_value = 32'hCAFE; rs1_num = 5'd7;
        @(negedge clk);
        chk("byp_b_val", 64'(b_rs1_value), 64'hCAFE);
        chk("byp_b_busy", 64'(b_rs1_busy), 64'd0);
        chk("byp_n_val", 64'(n_rs1_value), 64'd0);
        chk("byp_n_busy", 64'(n_rs1_busy), 64'd1);
        chk("byp_cnt", 64'(b_cnt), 64'd1);
        tick(); idle(); rs1_num = 5'd7;
        @(negedge clk);
        chk("byp_n_val2", 64'(n_rs1_value), 64'hCAFE);
        chk("byp_n_busy2", 64'(n_rs1_busy), 64'd0);
        chk("byp_cnt2", 64'(n_cnt), 64'd0);
        tick();

        // Scoreboard counting
        for (int r = 1; r <= 3; r++) begin
            issue_en = 1'b1; issue_num = AW'(r);
            tick();
        end
        idle();
        @(negedge clk);
        chk("sb_cnt3", 64'(b_cnt), 64'd3);
        tick();
        issue_en = 1'b1; issue_num = 5'd2;
        we0 = 1'b1; wd0_num = 5'd2; wd0_value = 32'h22;
        tick(); idle(); rs1_num = 5'd2;
        @(negedge clk);
        chk("sb_reiss_cnt", 64'(b_cnt), 64'd3);
        chk("sb_reiss_bbusy", 64'(b_rs1_busy), 64'd1);
        chk("sb_reiss_nbusy", 64'(n_rs1_busy), 64'd1);
        tick();
        we0 = 1'b1; wd0_num = 5'd1; wd0_value = 32'h11;
        we1 = 1'b1; wd1_num = 5'd3; wd1_value = 32'h33;
        tick(); idle();
        @(negedge clk);
        chk("sb_cnt1", 64'(b_cnt), 64'd1);
        chk("sb_cnt1_n", 64'(n_cnt), 64'd1);
        check_en = 1'b0;

        // Asynchronous reset between edges clears everything at once
        rs1_num = 5'd5; rs2_num = 5'd2;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cnt", 64'(b_cnt), 64'd0);
        chk("arst_x5", 64'(b_rs1_value), 64'd0);
        chk("arst_x2_busy", 64'(b_rs2_busy), 64'd0);
        for (int i = 1; i < int'(NREG); i++) begin
            rs1_num = AW'(i);
            rs2_num = AW'(i);
            #1;
            chk("arst_b_val", 64'(b_rs1_value), 64'd0);
            chk("arst_n_val", 64'(n_rs2_value), 64'd0);
            chk("arst_busy", 64'({b_rs1_busy, n_rs2_busy}), 64'd0);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        check_en = 1'b1;
        tick();

        // Random traffic against the model
        for (int c = 0; c < 10000; c++) begin
            we0       = 1'($urandom_range(0, 1));
            wd0_num   = rnd_idx();
            wd0_value = $urandom;
            we1       = 1'($urandom_range(0, 1));
            wd1_num   = rnd_idx();
            wd1_value = $urandom;
            issue_en  = ($urandom_range(0, 2) != 0);
            issue_num = rnd_idx();
            rs1_num   = rnd_idx();
            rs2_num   = rnd_idx();
            tick();
        end
        idle();
        tick();
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
